ts_injection_schedule: RTL and testbench

Upstream neighbour of the TS injection management stage, inside host_receive_process. Holds a host-configured, time-slot-indexed schedule table. At every time-slot switch it looks up the slot's entry; if the entry is valid, it issues the 5-bit TS flow injection address over a wr/ack handshake. It counts successful injections and flags slots lost because a handshake was still in progress.

---
 rtl/ts_injection_schedule.sv | 112 +++++++++++
 tb/tb_ts_injection_schedule.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_injection_schedule.sv
// Time-slot indexed injection schedule: looks up a host-loaded table at each
// slot switch and issues the TS flow id over a wr/ack handshake.
module ts_injection_schedule #(
  parameter int SLOT_W = 10,
  parameter int FLOW_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_schedule_en,
  input  logic [SLOT_W:0]   iv_schedule_period,
  input  logic [FLOW_W:0]   iv_cfg_wdata,
  input  logic [SLOT_W-1:0] iv_cfg_waddr,
  input  logic              i_cfg_wr,
  input  logic [SLOT_W-1:0] iv_time_slot,
  input  logic              i_time_slot_switch,
  output logic [FLOW_W-1:0] ov_ts_injection_addr,
  output logic              o_ts_injection_addr_wr,
  input  logic              i_ts_injection_addr_ack,
  output logic [31:0]       ov_inject_cnt,
  output logic              o_inject_miss_pulse,
  output logic [1:0]        ov_tis_state
);

  typedef enum logic [1:0] {
    IDLE_S     = 2'd0,
    READ_S     = 2'd1,
    WAIT_ACK_S = 2'd2,
    BAD_S      = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [FLOW_W:0]   tbl [2**SLOT_W];
  logic [FLOW_W:0]   rd_data;
  logic              rd_en;
  logic              slot_ok;
  logic              wr_n, miss_n;
  logic [FLOW_W-1:0] addr_n;
  logic [31:0]       cnt_n;

  // Table has no reset; read-before-write gives old data on a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_cfg_wr) tbl[iv_cfg_waddr] <= iv_cfg_wdata;
    if (rd_en)    rd_data <= tbl[iv_time_slot];
  end

  assign slot_ok = i_time_slot_switch && i_schedule_en &&
                   ({1'b0, iv_time_slot} < iv_schedule_period);

  always_comb begin
    state_n = state;
    wr_n    = o_ts_injection_addr_wr;
    addr_n  = ov_ts_injection_addr;
    cnt_n   = ov_inject_cnt;
    miss_n  = 1'b0;
    rd_en   = 1'b0;
    case (state)
      IDLE_S: begin
        wr_n   = 1'b0;
        addr_n = '0;
        if (slot_ok) begin
          rd_en   = 1'b1;
          state_n = READ_S;
        end
      end
      READ_S: begin
        // Any switch while busy is dropped, whatever its table entry holds.
        miss_n = i_time_slot_switch;
        if (rd_data[FLOW_W]) begin
          wr_n    = 1'b1;
          addr_n  = rd_data[FLOW_W-1:0];
          state_n = WAIT_ACK_S;
        end else begin
          state_n = IDLE_S;
        end
      end
      WAIT_ACK_S: begin
        miss_n = i_time_slot_switch;
        if (i_ts_injection_addr_ack) begin
          wr_n    = 1'b0;
          addr_n  = '0;
          cnt_n   = ov_inject_cnt + 32'd1;
          state_n = IDLE_S;
        end
      end
      default: begin
        state_n = IDLE_S;
        wr_n    = 1'b0;
        addr_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                  <= IDLE_S;
      o_ts_injection_addr_wr <= 1'b0;
      ov_ts_injection_addr   <= '0;
      ov_inject_cnt          <= '0;
      o_inject_miss_pulse    <= 1'b0;
    end else begin
      state                  <= state_n;
      o_ts_injection_addr_wr <= wr_n;
      ov_ts_injection_addr   <= addr_n;
      ov_inject_cnt          <= cnt_n;
      o_inject_miss_pulse    <= miss_n;
    end
  end

  assign ov_tis_state = state;

endmodule

// File: tb/tb_ts_injection_schedule.sv
// Bench for ts_injection_schedule: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ts_injection_schedule;
  localparam int SLOT_W = 10;
  localparam int FLOW_W = 5;
  localparam int NSLOT  = 2**SLOT_W;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_schedule_en = 1'b0;
  logic [SLOT_W:0]   iv_schedule_period = '0;
  logic [FLOW_W:0]   iv_cfg_wdata = '0;
  logic [SLOT_W-1:0] iv_cfg_waddr = '0;
  logic              i_cfg_wr = 1'b0;
  logic [SLOT_W-1:0] iv_time_slot = '0;
  logic              i_time_slot_switch = 1'b0;
  logic [FLOW_W-1:0] ov_ts_injection_addr;
  logic              o_ts_injection_addr_wr;
  logic              i_ts_injection_addr_ack = 1'b0;
  logic [31:0]       ov_inject_cnt;
  logic              o_inject_miss_pulse;
  logic [1:0]        ov_tis_state;

  ts_injection_schedule #(.SLOT_W(SLOT_W), .FLOW_W(FLOW_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_schedule_en(i_schedule_en),
    .iv_schedule_period(iv_schedule_period), .iv_cfg_wdata(iv_cfg_wdata),
    .iv_cfg_waddr(iv_cfg_waddr), .i_cfg_wr(i_cfg_wr), .iv_time_slot(iv_time_slot),
    .i_time_slot_switch(i_time_slot_switch), .ov_ts_injection_addr(ov_ts_injection_addr),
    .o_ts_injection_addr_wr(o_ts_injection_addr_wr),
    .i_ts_injection_addr_ack(i_ts_injection_addr_ack), .ov_inject_cnt(ov_inject_cnt),
    .o_inject_miss_pulse(o_inject_miss_pulse), .ov_tis_state(ov_tis_state)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a lookup in flight carries a snapshot of the entry taken
  // when the switch was accepted; a pending injection waits for its ack.
  logic [FLOW_W:0]   m_tbl [NSLOT];
  logic              m_look, m_wr, m_miss;
  logic [FLOW_W:0]   m_ent;
  logic [FLOW_W-1:0] m_addr;
  logic [31:0]       m_cnt;

  task automatic model_reset();
    m_look = 0; m_wr = 0; m_miss = 0; m_ent = '0; m_addr = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic busy;
    if (i_rst) begin
      model_reset();
    end else begin
      busy   = m_look || m_wr;
      m_miss = i_time_slot_switch && busy;
      if (m_wr && i_ts_injection_addr_ack) begin
        m_wr = 0; m_addr = '0; m_cnt = m_cnt + 1;
      end else if (m_look) begin
        m_look = 0;
        if (m_ent[FLOW_W]) begin
          m_wr = 1; m_addr = m_ent[FLOW_W-1:0];
        end
      end else if (!busy && i_time_slot_switch && i_schedule_en &&
                   (int'(iv_time_slot) < int'(iv_schedule_period))) begin
        m_look = 1;
        m_ent  = m_tbl[iv_time_slot];
      end
    end
    if (i_cfg_wr) m_tbl[iv_cfg_waddr] = iv_cfg_wdata;
  endtask

  task automatic check_outs();
    chk("wr",    {31'd0, o_ts_injection_addr_wr}, {31'd0, m_wr});
    chk("addr",  32'(ov_ts_injection_addr), 32'(m_addr));
    chk("cnt",   ov_inject_cnt, m_cnt);
    chk("miss",  {31'd0, o_inject_miss_pulse}, {31'd0, m_miss});
    chk("state", 32'(ov_tis_state), m_look ? 32'd1 : (m_wr ? 32'd2 : 32'd0));
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic step(input logic sw, input logic [SLOT_W-1:0] sl, input logic ack);
    i_time_slot_switch = sw;
    iv_time_slot = sl;
    i_ts_injection_addr_ack = ack;
    cyc();
    i_time_slot_switch = 0;
    i_ts_injection_addr_ack = 0;
    i_cfg_wr = 0;
  endtask

  task automatic cfg_write(input logic [SLOT_W-1:0] a, input logic [FLOW_W:0] d);
    i_cfg_wr = 1; iv_cfg_waddr = a; iv_cfg_wdata = d;
    step(0, '0, 0);
  endtask

  initial begin
    int misses;
    model_reset();
    #1;
    chk("rst_wr",    {31'd0, o_ts_injection_addr_wr}, 32'd0);
    chk("rst_state", 32'(ov_tis_state), 32'd0);
    repeat (2) cyc();
    i_rst = 0;
    for (int a = 0; a < NSLOT; a++) cfg_write(SLOT_W'(a), '0);

    // basic injection, ack one cycle after wr
    cfg_write(10'd3, {1'b1, 5'd7});
    iv_schedule_period = 11'd8; i_schedule_en = 1;
    step(1, 10'd3, 0);
    step(0, '0, 0);
    chk("tp1_wr", {31'd0, o_ts_injection_addr_wr}, 32'd1);
    chk("tp1_addr", 32'(ov_ts_injection_addr), 32'd7);
    step(0, '0, 1);
    chk("tp1_wr_lo", {31'd0, o_ts_injection_addr_wr}, 32'd0);
    chk("tp1_cnt", ov_inject_cnt, 32'd1);

    // invalid entry: lookup only
    cfg_write(10'd4, {1'b0, 5'd9});
    step(1, 10'd4, 0);
    chk("tp2_read", 32'(ov_tis_state), 32'd1);
    step(0, '0, 0);
    chk("tp2_idle", 32'(ov_tis_state), 32'd0);
    chk("tp2_cnt", ov_inject_cnt, 32'd1);

    // period limits
    cfg_write(10'd5, {1'b1, 5'd5});
    iv_schedule_period = 11'd4;
    step(1, 10'd5, 0);
    chk("tp3_no_lookup", 32'(ov_tis_state), 32'd0);
    iv_schedule_period = 11'd0;
    for (int s = 0; s < 8; s++) step(1, SLOT_W'(s), 0);
    step(0, '0, 0);
    chk("tp3_p0_cnt", ov_inject_cnt, 32'd1);

    // long ack stall with a dropped slot
    iv_schedule_period = 11'd8;
    cfg_write(10'd6, {1'b1, 5'd6});
    step(1, 10'd3, 0);
    step(0, '0, 0);
    misses = 0;
    for (int i = 0; i < 20; i++) begin
      step(i == 3, 10'd6, 0);
      misses += int'(o_inject_miss_pulse);
    end
    chk("tp4_addr_held", 32'(ov_ts_injection_addr), 32'd7);
    chk("tp4_miss_cnt", 32'(misses), 32'd1);
    step(0, '0, 1);
    chk("tp4_cnt", ov_inject_cnt, 32'd2);
    repeat (3) step(0, '0, 0);
    chk("tp4_no_slot6", {31'd0, o_ts_injection_addr_wr}, 32'd0);

    // write/lookup collision returns the old entry
    cfg_write(10'd2, {1'b1, 5'd11});
    i_cfg_wr = 1; iv_cfg_waddr = 10'd2; iv_cfg_wdata = {1'b1, 5'd21};
    step(1, 10'd2, 0);
    step(0, '0, 0);
    chk("tp5_old", 32'(ov_ts_injection_addr), 32'd11);
    step(0, '0, 1);
    step(1, 10'd2, 0);
    step(0, '0, 0);
    chk("tp5_new", 32'(ov_ts_injection_addr), 32'd21);
    step(0, '0, 1);
    chk("tp5_cnt", ov_inject_cnt, 32'd4);

    // asynchronous reset mid-handshake
    step(1, 10'd3, 0);
    step(0, '0, 0);
    i_rst = 1;
    #1;
    model_reset();
    chk("tp6_wr", {31'd0, o_ts_injection_addr_wr}, 32'd0);
    chk("tp6_addr", 32'(ov_ts_injection_addr), 32'd0);
    chk("tp6_cnt", ov_inject_cnt, 32'd0);
    chk("tp6_state", 32'(ov_tis_state), 32'd0);
    step(0, '0, 0);
    i_rst = 0;
    step(0, '0, 0);
    step(1, 10'd3, 0);
    step(0, '0, 0);
    chk("tp6_reinject", 32'(ov_ts_injection_addr), 32'd7);
    step(0, '0, 1);
    chk("tp6_cnt1", ov_inject_cnt, 32'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 4))
          0: iv_schedule_period = 11'd0;
          1: iv_schedule_period = 11'd16;
          2: iv_schedule_period = 11'(NSLOT);
          default: iv_schedule_period = 11'($urandom_range(0, NSLOT));
        endcase
      end
      if ($urandom_range(0, 99) == 0) i_schedule_en = ~i_schedule_en;
      if ($urandom_range(0, 5) == 0) begin
        i_cfg_wr = 1;
        iv_cfg_waddr = 10'($urandom_range(0, 31));
        iv_cfg_wdata = 6'($urandom);
      end
      step($urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31)),
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
